// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_defs_pkg
//  Purpose  : State codes, opcodes and mux-select encodings shared by the
//             multi-cycle controller, datapath and bench.
//  Revision : 1.0
// ============================================================================
package cpu_defs_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_BEQ      = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;

    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT  = 2'b00;
    localparam logic [1:0] c_RES_MEMDATA = 2'b01;
    localparam logic [1:0] c_RES_ALU     = 2'b10;

    // Instruction boundary: a dropped run enable parks the controller in IDLE.
    function automatic state_e boundary_next(input logic run);
        return run ? S_FETCH : S_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_ctrl
//  Purpose  : Moore control FSM for a multi-cycle RISC-V style core with a
//             unified, variable-latency memory.
//  Revision : 1.0
// ============================================================================
module multi_cycle_ctrl
    import cpu_defs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       adrSrc,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] resultSrc,
    output logic [3:0] state,
    output logic       halted
);

    state_e r_state_q;
    state_e w_state_d;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:     if (start) w_state_d = S_FETCH;
            S_FETCH:    if (mem_ready) w_state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_OP_LOAD, c_OP_STORE: w_state_d = S_MEMADR;
                    c_OP_RTYPE:            w_state_d = S_EXECR;
                    c_OP_ITYPE:            w_state_d = S_EXECI;
                    c_OP_JAL:              w_state_d = S_JAL;
                    c_OP_BRANCH:           w_state_d = S_BEQ;
                    default:               w_state_d = S_HALT;
                endcase
            end
            S_MEMADR:   w_state_d = (opcode == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_state_d = S_MEMWB;
            S_MEMWB:    w_state_d = boundary_next(start);
            S_MEMWRITE: if (mem_ready) w_state_d = boundary_next(start);
            S_EXECR:    w_state_d = S_ALUWB;
            S_EXECI:    w_state_d = S_ALUWB;
            S_ALUWB:    w_state_d = boundary_next(start);
            S_JAL:      w_state_d = S_ALUWB;
            S_BEQ:      w_state_d = boundary_next(start);
            S_HALT:     w_state_d = S_HALT;
            default:    w_state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state_q <= S_IDLE;
        else      r_state_q <= w_state_d;
    end

    // Outputs decode the state flop directly so reset silences them at once.
    always_comb begin
        pcWrite   = 1'b0;
        irWrite   = 1'b0;
        adrSrc    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        regWrite  = 1'b0;
        ALUSrcA   = c_SRCA_PC;
        ALUSrcB   = c_SRCB_RS2;
        ALUOp     = c_ALUOP_ADD;
        resultSrc = c_RES_ALUOUT;
        halted    = 1'b0;
        case (r_state_q)
            S_FETCH: begin
                memRead   = 1'b1;
                ALUSrcB   = c_SRCB_FOUR;
                resultSrc = c_RES_ALU;
                irWrite   = mem_ready;
                pcWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = c_SRCA_RS1;
                ALUSrcB = c_SRCB_IMM;
            end
            S_MEMREAD: begin
                adrSrc  = 1'b1;
                memRead = 1'b1;
            end
            S_MEMWB: begin
                resultSrc = c_RES_MEMDATA;
                regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = c_SRCA_RS1;
                ALUOp   = c_ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = c_SRCA_RS1;
                ALUSrcB = c_SRCB_IMM;
                ALUOp   = c_ALUOP_FUNCT;
            end
            S_ALUWB:  regWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_FOUR;
                pcWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = c_SRCA_RS1;
                ALUOp   = c_ALUOP_SUB;
                pcWrite = zero;
            end
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    assign state = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_cycle_ctrl
//  Purpose  : Self-checking bench for multi_cycle_ctrl: vector table, directed
//             corner sequences and random instruction streams.
//  Revision : 1.0
// ============================================================================
module tb_multi_cycle_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcWrite, irWrite, adrSrc, memRead, memWrite, regWrite, halted;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, resultSrc;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pcWrite(pcWrite), .irWrite(irWrite),
        .adrSrc(adrSrc), .memRead(memRead), .memWrite(memWrite),
        .regWrite(regWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .resultSrc(resultSrc), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    // Output layout: {pcW, irW, adrSrc, memRd, memWr, regW, A, B, Op, Res, halted}
    function automatic logic [14:0] ref_outs(input int st, input logic mr, input logic z);
        logic pcw, irw, adr, mrd, mwr, rgw, hlt;
        logic [1:0] a, b, op, rs;
        {pcw, irw, adr, mrd, mwr, rgw, hlt} = 7'b0;
        {a, b, op, rs} = 8'b0;
        case (st)
            1:  begin mrd = 1; b = 2'b10; rs = 2'b10; pcw = mr; irw = mr; end
            2:  begin a = 2'b01; b = 2'b01; end
            3:  begin a = 2'b10; b = 2'b01; end
            4:  begin adr = 1; mrd = 1; end
            5:  begin rs = 2'b01; rgw = 1; end
            6:  begin adr = 1; mwr = 1; end
            7:  begin a = 2'b10; op = 2'b10; end
            8:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
            9:  rgw = 1;
            10: begin a = 2'b01; b = 2'b10; pcw = 1; end
            11: begin a = 2'b10; op = 2'b01; pcw = z; end
            12: hlt = 1;
            default: ;
        endcase
        return {pcw, irw, adr, mrd, mwr, rgw, a, b, op, rs, hlt};
    endfunction

    task automatic check(input string name, input int exp_st, input logic [14:0] exp_o);
        logic [14:0] act;
        act = {pcWrite, irWrite, adrSrc, memRead, memWrite, regWrite,
               ALUSrcA, ALUSrcB, ALUOp, resultSrc, halted};
        n_cmp++;
        if (state !== 4'(exp_st) || act !== exp_o) begin
            n_bad++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, state, act, exp_st, exp_o);
        end
    endtask

    // Called just after a rising edge: drive, settle, compare, advance one cycle.
    task automatic step(input logic s, input logic [6:0] op, input logic z,
                        input logic mr, input int exp_st, input string name);
        start = s; opcode = op; zero = z; mem_ready = mr;
        #1;
        check(name, exp_st, ref_outs(exp_st, mr, z));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       s;
        logic [6:0] op;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic [5:0] flags;   // {pcW, irW, adrSrc, memRd, memWr, regW}
    } vec_t;

    vec_t vecs[19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          w;
        int          cls;
        logic        run;
        logic [6:0]  op;
        int          plan[$];

        vecs[0]  = '{1'b1, OP_R,   1'b0, 1'b1, 4'd0,  6'b000000};
        vecs[1]  = '{1'b1, OP_R,   1'b0, 1'b1, 4'd1,  6'b110100};
        vecs[2]  = '{1'b1, OP_R,   1'b0, 1'b1, 4'd2,  6'b000000};
        vecs[3]  = '{1'b1, OP_R,   1'b0, 1'b1, 4'd7,  6'b000000};
        vecs[4]  = '{1'b1, OP_R,   1'b0, 1'b1, 4'd9,  6'b000001};
        vecs[5]  = '{1'b1, OP_BEQ, 1'b0, 1'b0, 4'd1,  6'b000100};
        vecs[6]  = '{1'b1, OP_BEQ, 1'b0, 1'b1, 4'd1,  6'b110100};
        vecs[7]  = '{1'b1, OP_BEQ, 1'b0, 1'b1, 4'd2,  6'b000000};
        vecs[8]  = '{1'b1, OP_BEQ, 1'b1, 1'b1, 4'd11, 6'b100000};
        vecs[9]  = '{1'b1, OP_BEQ, 1'b0, 1'b1, 4'd1,  6'b110100};
        vecs[10] = '{1'b1, OP_BEQ, 1'b0, 1'b1, 4'd2,  6'b000000};
        vecs[11] = '{1'b1, OP_BEQ, 1'b0, 1'b1, 4'd11, 6'b000000};
        vecs[12] = '{1'b1, OP_SW,  1'b0, 1'b1, 4'd1,  6'b110100};
        vecs[13] = '{1'b1, OP_SW,  1'b0, 1'b1, 4'd2,  6'b000000};
        vecs[14] = '{1'b1, OP_SW,  1'b0, 1'b1, 4'd3,  6'b000000};
        vecs[15] = '{1'b1, OP_SW,  1'b0, 1'b0, 4'd6,  6'b001010};
        vecs[16] = '{1'b0, OP_SW,  1'b0, 1'b1, 4'd6,  6'b001010};
        vecs[17] = '{1'b0, OP_SW,  1'b0, 1'b0, 4'd0,  6'b000000};
        vecs[18] = '{1'b0, OP_R,   1'b0, 1'b1, 4'd0,  6'b000000};

        // Reset held across edges with start high.
        repeat (2) @(posedge clk);
        #1;
        check("reset_idle", 0, 15'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            logic [9:0] act, exp;
            start = vecs[i].s; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            act = {state, pcWrite, irWrite, adrSrc, memRead, memWrite, regWrite};
            exp = {vecs[i].st, vecs[i].flags};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL vec[%0d]: got state/flags=%b, expected %b", i, act, exp);
            end
            @(posedge clk); #1;
        end

        // Load with three memory wait cycles.
        step(1, OP_LW, 0, 0, 0, "lw_idle");
        step(1, OP_LW, 0, 1, 1, "lw_fetch");
        step(1, OP_LW, 0, 1, 2, "lw_decode");
        step(1, OP_LW, 0, 1, 3, "lw_memadr");
        for (int k = 0; k < 3; k++) step(1, OP_LW, 0, 0, 4, "lw_memread_wait");
        step(1, OP_LW, 0, 1, 4, "lw_memread_done");
        step(0, OP_LW, 0, 1, 5, "lw_memwb");
        step(0, OP_LW, 0, 0, 0, "lw_back_idle");

        // Illegal opcode: sticky halt regardless of start, cleared only by reset.
        step(1, OP_BAD, 0, 0, 0, "halt_idle");
        step(1, OP_BAD, 0, 1, 1, "halt_fetch");
        step(1, OP_BAD, 0, 1, 2, "halt_decode");
        for (int k = 0; k < 20; k++) step(logic'(k % 2), OP_R, 0, 1, 12, "halt_hold");
        #2 rst = 1'b0;
        #1 check("halt_reset_async", 0, 15'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(0, OP_R, 0, 1, 0, "halt_after_reset");

        // Store interrupted by reset during its memory wait.
        step(1, OP_SW, 0, 0, 0, "sw_idle");
        step(1, OP_SW, 0, 1, 1, "sw_fetch");
        step(1, OP_SW, 0, 1, 2, "sw_decode");
        step(1, OP_SW, 0, 1, 3, "sw_memadr");
        step(1, OP_SW, 0, 0, 6, "sw_memwrite_wait");
        #1 check("sw_still_waiting", 6, ref_outs(6, 1'b0, 1'b0));
        #1 rst = 1'b0;
        #1 check("sw_reset_drop", 0, 15'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Random instruction streams against per-class state plans.
        step(1, OP_R, 0, 0, 0, "rand_start");
        for (int n = 0; n < 60; n++) begin
            cls = int'($urandom_range(0, 5));
            run = ($urandom_range(0, 3) != 0);
            case (cls)
                0:       begin op = OP_R;   plan = '{1, 2, 7, 9};    end
                1:       begin op = OP_I;   plan = '{1, 2, 8, 9};    end
                2:       begin op = OP_LW;  plan = '{1, 2, 3, 4, 5}; end
                3:       begin op = OP_SW;  plan = '{1, 2, 3, 6};    end
                4:       begin op = OP_JAL; plan = '{1, 2, 10, 9};   end
                default: begin op = OP_BEQ; plan = '{1, 2, 11};      end
            endcase
            foreach (plan[j]) begin
                if (plan[j] == 1 || plan[j] == 4 || plan[j] == 6) begin
                    w = int'($urandom_range(0, 3));
                    for (int k = 0; k <= w; k++)
                        step(run, op, logic'($urandom_range(0, 1)), (k == w), plan[j], "rand_wait");
                end else begin
                    step(run, op, logic'($urandom_range(0, 1)),
                         logic'($urandom_range(0, 1)), plan[j], "rand_step");
                end
            end
            if (!run) step(1, op, 0, 0, 0, "rand_idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-low reset (rst=0 resets immediately, regardless of clk).
REQ-003 SHALL have start, input, 1, run enable; 0 holds the controller in IDLE.
REQ-004 SHALL have opcode, input, 7, instr[6:0] from the instruction register.
REQ-005 SHALL have zero, input, 1, ALU zero flag.
REQ-006 SHALL have mem_ready, input, 1, unified memory completes the current access this cycle.
REQ-007 SHALL have outputs pcWrite, irWrite, adrSrc, memRead, memWrite, regWrite (each 1 bit): PC load, IR load, address select (0=PC, 1=ALUOut), memory read request, memory write request, register-file write.
REQ-008 SHALL have outputs ALUSrcA[1:0] (00=PC, 01=oldPC, 10=rs1), ALUSrcB[1:0] (00=rs2, 01=imm, 10=const 4), ALUOp[1:0] (00=add, 01=sub, 10=funct-decoded), resultSrc[1:0] (00=ALUOut reg, 01=mem data, 10=ALU result).
REQ-009 SHALL have outputs state[3:0] (debug, current state code) and halted (1 bit, sticky illegal-opcode flag).

Function
REQ-010 SHALL implement a Moore FSM with states IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, JAL=10, BEQ=11, HALT=12; codes 13-15 SHALL transition to HALT.
REQ-011 SHALL transition IDLE->FETCH when start=1, else remain in IDLE; all outputs are 0 in IDLE.
REQ-012 FETCH SHALL drive adrSrc=0, memRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, resultSrc=10; it remains in FETCH while mem_ready=0, with irWrite=pcWrite=0.
REQ-013 In FETCH with mem_ready=1, irWrite and pcWrite SHALL both be 1 for exactly that cycle (Mealy qualification on mem_ready), next state DECODE.
REQ-014 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute), then branch on opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL, 1100011->BEQ, any other->HALT.
REQ-015 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD if opcode=0000011, else MEMWRITE.
REQ-016 MEMREAD SHALL drive adrSrc=1, memRead=1, resultSrc=00, and hold until mem_ready=1, then go to MEMWB.
REQ-017 MEMWRITE SHALL drive adrSrc=1, memWrite=1, and hold until mem_ready=1, then go to FETCH; memWrite SHALL stay asserted every waiting cycle.
REQ-018 MEMWB SHALL drive resultSrc=01, regWrite=1, then go to FETCH.
REQ-019 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; both go to ALUWB.
REQ-020 ALUWB SHALL drive resultSrc=00, regWrite=1, then go to FETCH.
REQ-021 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, resultSrc=00, pcWrite=1, then go to ALUWB (rd=oldPC+4).
REQ-022 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, resultSrc=00, pcWrite=zero, then go to FETCH.
REQ-023 HALT SHALL drive all outputs 0 except halted=1 and SHALL be left only by reset; start has no effect there.
REQ-024 start falling to 0 mid-instruction SHALL NOT abort it; the FSM returns to IDLE instead of FETCH at the next instruction boundary.
REQ-025 memRead and memWrite SHALL never be 1 in the same cycle; regWrite and memWrite SHALL never be 1 in the same cycle.
REQ-026 Instruction latency with mem_ready tied to 1: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 4; every wait cycle adds one.

Reset
REQ-027 On rst=0 the state SHALL be IDLE, halted=0, and every output 0, asynchronously and held while rst=0.
REQ-028 Reset asserted during a memory wait SHALL drop memRead/memWrite in the same cycle without waiting for mem_ready.

Structure
REQ-029 State encodings, opcode constants and mux-select encodings SHALL live in the shared package (cpu_defs_pkg) for reuse by datapath and bench.
REQ-030 SHALL consist of one state register plus combinational next-state and output logic; no sub-module is needed.

Verification
REQ-031 rst=0 with start=1 -> state=0, all outputs 0; release rst with start=1 -> FETCH on next edge with memRead=1.
REQ-032 add (0110011), mem_ready=1 -> state sequence 1,2,7,9,1; regWrite=1 only in state 9.
REQ-033 lw with mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles with adrSrc=1, then MEMWB with regWrite=1, resultSrc=01.
REQ-034 beq with zero=1 -> pcWrite=1 in BEQ; with zero=0 -> pcWrite=0; both return to FETCH.
REQ-035 opcode 1111111 in DECODE -> HALT, halted=1 held for 20 cycles with start toggling; rst pulse -> IDLE, halted=0.
REQ-036 sw with rst asserted mid-wait -> memWrite=0 immediately, state=0 before the next edge.
